// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter sharing one fifo between NUM_REQ valid/ready producers.
// Define FIFO_ARB_STATS_EN to add saturating per-requester accept counters (accept_count).
module fifo_write_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          fifo_write_en,
  input  logic                          fifo_full,
  output logic [$clog2(NUM_REQ)-1:0]    fifo_wr_id,
  output logic                          busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         accept_count
`endif
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e                state_q, state_d;
  logic [IdW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]        owner_q, owner_d;
  logic [CntW-1:0]       burst_cnt_q, burst_cnt_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [IdW-1:0]        hold_id_q, hold_id_d;

  logic                  slot_free;
  logic                  accept;
  logic [IdW-1:0]        acc_id;
  logic [DATA_WIDTH-1:0] acc_data;
  logic [IdW-1:0]        scan_idx;
  logic [IdW-1:0]        win_id;
  logic                  win_found;

  function automatic logic [IdW-1:0] inc_ptr(input logic [IdW-1:0] ptr);
    return IdW'((32'(ptr) + 32'd1) % NUM_REQ);
  endfunction

  // Write is suppressed during reset so a held beat is discarded, never emitted.
  assign fifo_write_en = hold_valid_q & ~fifo_full & ~reset;
  assign slot_free     = ~hold_valid_q | fifo_write_en;
  assign accept        = |(req_valid & req_ready);
  assign acc_id        = (state_q == StOwn) ? owner_q : win_id;
  assign fifo_din      = hold_data_q;
  assign fifo_wr_id    = hold_id_q;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = IdW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  always_comb begin
    acc_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (acc_id == IdW'(i)) acc_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      burst_cnt_q  <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      burst_cnt_q  <= burst_cnt_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_id_q    <= hold_id_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (MAX_BURST == 1) begin
            rr_ptr_d = inc_ptr(win_id);
          end else begin
            state_d     = StOwn;
            owner_d     = win_id;
            burst_cnt_d = CntW'(1);
          end
        end
      end
      StOwn: begin
        if (!req_valid[owner_q]) begin
          state_d  = StIdle;
          rr_ptr_d = inc_ptr(owner_q);
        end else if (accept) begin
          burst_cnt_d = burst_cnt_q + CntW'(1);
          if (burst_cnt_d == CntW'(MAX_BURST)) begin
            state_d  = StIdle;
            rr_ptr_d = inc_ptr(owner_q);
          end
        end
      end
    endcase
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_id_d    = hold_id_q;
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_data_d  = acc_data;
      hold_id_d    = acc_id;
    end else if (fifo_write_en) begin
      hold_valid_d = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    busy      = (state_q == StOwn);
    if (!reset && slot_free) begin
      unique case (state_q)
        StIdle: if (win_found) req_ready[win_id] = 1'b1;
        StOwn:  req_ready[owner_q] = req_valid[owner_q];
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] acc_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && acc_cnt_q[i] != 16'hFFFF) begin
          acc_cnt_q[i] <= acc_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign accept_count = acc_cnt_q;
`endif

endmodule
